reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Integer/branch reservation station directly downstream of the register file.
- Accepts renamed ALU/branch instructions on the register file's rs_* outputs and holds them until both operands are valid.
- Captures operand values broadcast on the CDB (ALU results) and LDB (load results).
- Issues at most one ready instruction per cycle to the ALU, oldest-slot-first by index.
- Flushes completely on a branch mispredict.

Parameters:
RS_BIT, 3, log2 of entry count (8 entries)
Widths `OP_W, `DAT_W, `ROB_BIT come from head.v. ROB tag 0 means "no dependency / value valid".

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global enable (full control); 0 freezes all state
br_flag  in  1  mispredict flush
rf_en_i  in  1  new instruction valid (from register file rs_en_o)
rf_ic_i  in  1  compressed-instruction flag
rf_op_i  in  `OP_W  opcode
rf_imm_i  in  `DAT_W  immediate
rf_qj_i, rf_qk_i  in  `ROB_BIT each  source tags (0 = ready)
rf_vj_i, rf_vk_i  in  `DAT_W each  source values
rf_qd_i  in  `ROB_BIT  destination ROB tag
rf_pc_i  in  `DAT_W  instruction pc
cdb_en_i  in  1  ALU result broadcast valid
cdb_q_i  in  `ROB_BIT  broadcast tag
cdb_v_i  in  `DAT_W  broadcast value
ldb_en_i  in  1  load result broadcast valid
ldb_q_i  in  `ROB_BIT  load tag
ldb_v_i  in  `DAT_W  load value
full_o  out  1  stall request to issue stage (combinational)
alu_en_o  out  1  dispatch valid (registered)
alu_ic_o  out  1  compressed-instruction flag of dispatched entry
alu_op_o  out  `OP_W  opcode of dispatched entry
alu_vj_o, alu_vk_o  out  `DAT_W each  operand values of dispatched entry
alu_imm_o  out  `DAT_W  immediate of dispatched entry
alu_pc_o  out  `DAT_W  pc of dispatched entry
alu_qd_o  out  `ROB_BIT  destination ROB tag of dispatched entry

Behaviour:
- Per entry: busy, ic, op, imm, qj, qk, vj, vk, qd, pc.
- Reset and flush:
  - rst or br_flag (priority over en): all busy cleared, all alu_* outputs 0.
  - Stored fields of freed entries are don't-care.
- en=0, rst=0, br_flag=0: no state change. alu_en_o is forced 0 next edge.
- Allocation:
  - On rf_en_i, write into the lowest-index non-busy entry; set busy.
  - Same-cycle capture: if rf_qj_i!=0 and (cdb_en_i && cdb_q_i==rf_qj_i), store qj=0, vj=cdb_v_i. Same for ldb. Same for qk/vk.
  - If both CDB and LDB match, LDB wins (tags are unique, so both matching cannot legally occur).
- Wakeup: every cycle, each busy entry with qj==cdb_q_i (cdb_en_i, qj!=0) takes qj<=0, vj<=cdb_v_i. Same for LDB and for qk/vk. Both operands of one entry may wake in the same cycle from different buses.
- Dispatch:
  - Ready = busy && qj==0 && qk==0, evaluated on current register state.
  - The lowest-index ready entry is copied to alu_* and alu_en_o<=1 at the edge; that entry's busy is cleared at the same edge.
  - No ready entry: alu_en_o<=0, other alu_* hold.
  - Latency: an entry allocated with both tags 0 at edge N dispatches at edge N+1 (alu_en_o high after N+1). An entry woken at edge N dispatches at edge N+1. There is no same-edge allocate-and-dispatch or wake-and-dispatch.
- Allocation and dispatch in the same cycle:
  - A full station with one dispatching entry cannot reuse that slot that cycle.
  - A new instruction goes to another free slot; if none exists it is dropped.
  - Dropping is illegal usage; full_o prevents it.
- full_o = (number of non-busy entries) < 2. The margin covers the one-cycle register-file pipeline delay.
- rf_en_i is never accepted in the br_flag cycle.
- Tag 0 on CDB/LDB is ignored.

Test Plan:
1. Reset, then rf_en_i with op=ADD, qj=qk=0, vj=5, vk=7, qd=3, pc=0x100 → next edge alu_en_o=1, vj=5, vk=7, qd=3, pc=0x100; following cycle alu_en_o=0.
2. Insert qj=4, qk=0, vk=9; two cycles later cdb_en_i q=4 v=0x22 → alu_en_o=1 one edge after the broadcast with vj=0x22, vk=9.
3. Insert qj=6 in the same cycle as ldb_en_i q=6 v=0xAB → captured at allocation; dispatches the next edge with vj=0xAB.
4. Fill 7 entries all waiting on tag 9 → full_o=1 once free count is 1. Broadcast cdb q=9 → entries dispatch one per cycle in index order 0..6; full_o drops once 2 slots are free.
5. Entries 0 and 2 ready, entry 1 waiting → entry 0 dispatches, then entry 2, entry 1 stays. Assert br_flag → entry 1 gone, alu_en_o=0, full_o=0, and no further dispatch after a later matching CDB.
6. en=0 for 3 cycles while a ready entry and a matching CDB broadcast are present → no dispatch, no capture. en=1 → resumes, and the missed broadcast is not captured.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: 8-entry integer/branch station holding renamed ops until both operands are valid,
// capturing CDB/LDB broadcasts and issuing the lowest-index ready entry to the ALU each cycle.
module reservation_station #(
   parameter int RS_BIT  = 3,
   parameter int OP_W    = 6,
   parameter int DAT_W   = 32,
   parameter int ROB_BIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               br_flag,
   input  logic               rf_en_i,
   input  logic               rf_ic_i,
   input  logic [OP_W-1:0]    rf_op_i,
   input  logic [DAT_W-1:0]   rf_imm_i,
   input  logic [ROB_BIT-1:0] rf_qj_i,
   input  logic [ROB_BIT-1:0] rf_qk_i,
   input  logic [DAT_W-1:0]   rf_vj_i,
   input  logic [DAT_W-1:0]   rf_vk_i,
   input  logic [ROB_BIT-1:0] rf_qd_i,
   input  logic [DAT_W-1:0]   rf_pc_i,
   input  logic               cdb_en_i,
   input  logic [ROB_BIT-1:0] cdb_q_i,
   input  logic [DAT_W-1:0]   cdb_v_i,
   input  logic               ldb_en_i,
   input  logic [ROB_BIT-1:0] ldb_q_i,
   input  logic [DAT_W-1:0]   ldb_v_i,
   output logic               full_o,
   output logic               alu_en_o,
   output logic               alu_ic_o,
   output logic [OP_W-1:0]    alu_op_o,
   output logic [DAT_W-1:0]   alu_vj_o,
   output logic [DAT_W-1:0]   alu_vk_o,
   output logic [DAT_W-1:0]   alu_imm_o,
   output logic [DAT_W-1:0]   alu_pc_o,
   output logic [ROB_BIT-1:0] alu_qd_o
);
   localparam int RS = 1 << RS_BIT;
   logic [RS-1:0]      busy, ic;
   logic [OP_W-1:0]    op  [RS];
   logic [DAT_W-1:0]   imm [RS];
   logic [ROB_BIT-1:0] qj  [RS];
   logic [ROB_BIT-1:0] qk  [RS];
   logic [DAT_W-1:0]   vj  [RS];
   logic [DAT_W-1:0]   vk  [RS];
   logic [ROB_BIT-1:0] qd  [RS];
   logic [DAT_W-1:0]   pc  [RS];
   logic [RS_BIT-1:0]  free_idx, rdy_idx;
   logic [RS_BIT:0]    free_cnt;
   logic               has_free, has_rdy;
   logic               cj, lj, ck, lk;
   logic [ROB_BIT-1:0] cap_qj, cap_qk;
   logic [DAT_W-1:0]   cap_vj, cap_vk;

   always_comb begin
      free_cnt = '0;
      free_idx = '0;
      rdy_idx  = '0;
      has_free = 1'b0;
      has_rdy  = 1'b0;
      for (int i = RS - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_idx = i[RS_BIT-1:0];
            has_free = 1'b1;
            free_cnt = free_cnt + (RS_BIT+1)'(1);
         end
         if (busy[i] && qj[i] == '0 && qk[i] == '0) begin
            rdy_idx = i[RS_BIT-1:0];
            has_rdy = 1'b1;
         end
      end
   end

   // same-cycle capture for the incoming instruction; LDB takes precedence
   assign cj     = cdb_en_i && rf_qj_i != '0 && cdb_q_i == rf_qj_i;
   assign lj     = ldb_en_i && rf_qj_i != '0 && ldb_q_i == rf_qj_i;
   assign ck     = cdb_en_i && rf_qk_i != '0 && cdb_q_i == rf_qk_i;
   assign lk     = ldb_en_i && rf_qk_i != '0 && ldb_q_i == rf_qk_i;
   assign cap_qj = (cj || lj) ? '0 : rf_qj_i;
   assign cap_qk = (ck || lk) ? '0 : rf_qk_i;
   assign cap_vj = lj ? ldb_v_i : cj ? cdb_v_i : rf_vj_i;
   assign cap_vk = lk ? ldb_v_i : ck ? cdb_v_i : rf_vk_i;
   assign full_o = free_cnt < (RS_BIT+1)'(2);

   always_ff @(posedge clk) begin
      if (rst || br_flag) begin
         busy      <= '0;
         alu_en_o  <= 1'b0;
         alu_ic_o  <= 1'b0;
         alu_op_o  <= '0;
         alu_vj_o  <= '0;
         alu_vk_o  <= '0;
         alu_imm_o <= '0;
         alu_pc_o  <= '0;
         alu_qd_o  <= '0;
      end else if (en) begin
         for (int i = 0; i < RS; i++) begin
            if (busy[i]) begin
               if (cdb_en_i && cdb_q_i != '0 && qj[i] == cdb_q_i) begin
                  qj[i] <= '0;
                  vj[i] <= cdb_v_i;
               end
               if (cdb_en_i && cdb_q_i != '0 && qk[i] == cdb_q_i) begin
                  qk[i] <= '0;
                  vk[i] <= cdb_v_i;
               end
               if (ldb_en_i && ldb_q_i != '0 && qj[i] == ldb_q_i) begin
                  qj[i] <= '0;
                  vj[i] <= ldb_v_i;
               end
               if (ldb_en_i && ldb_q_i != '0 && qk[i] == ldb_q_i) begin
                  qk[i] <= '0;
                  vk[i] <= ldb_v_i;
               end
            end
         end
         alu_en_o <= has_rdy;
         if (has_rdy) begin
            busy[rdy_idx] <= 1'b0;
            alu_ic_o      <= ic[rdy_idx];
            alu_op_o      <= op[rdy_idx];
            alu_vj_o      <= vj[rdy_idx];
            alu_vk_o      <= vk[rdy_idx];
            alu_imm_o     <= imm[rdy_idx];
            alu_pc_o      <= pc[rdy_idx];
            alu_qd_o      <= qd[rdy_idx];
         end
         // the dispatching slot is still busy here, so it is never chosen for reuse
         if (rf_en_i && has_free) begin
            busy[free_idx] <= 1'b1;
            ic[free_idx]   <= rf_ic_i;
            op[free_idx]   <= rf_op_i;
            imm[free_idx]  <= rf_imm_i;
            qj[free_idx]   <= cap_qj;
            qk[free_idx]   <= cap_qk;
            vj[free_idx]   <= cap_vj;
            vk[free_idx]   <= cap_vk;
            qd[free_idx]   <= rf_qd_i;
            pc[free_idx]   <= rf_pc_i;
         end
      end else begin
         alu_en_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenario bench for reservation_station with hand-computed expectations.
module tb_reservation_station;
   localparam int OP_W = 6, DAT_W = 32, ROB_BIT = 4;
   logic               clk = 1'b0;
   logic               rst, en, br_flag, rf_en_i, rf_ic_i, cdb_en_i, ldb_en_i;
   logic [OP_W-1:0]    rf_op_i;
   logic [DAT_W-1:0]   rf_imm_i, rf_vj_i, rf_vk_i, rf_pc_i, cdb_v_i, ldb_v_i;
   logic [ROB_BIT-1:0] rf_qj_i, rf_qk_i, rf_qd_i, cdb_q_i, ldb_q_i;
   logic               full_o, alu_en_o, alu_ic_o;
   logic [OP_W-1:0]    alu_op_o;
   logic [DAT_W-1:0]   alu_vj_o, alu_vk_o, alu_imm_o, alu_pc_o;
   logic [ROB_BIT-1:0] alu_qd_o;
   int checks = 0, failures = 0;

   reservation_station dut (
      .clk(clk), .rst(rst), .en(en), .br_flag(br_flag),
      .rf_en_i(rf_en_i), .rf_ic_i(rf_ic_i), .rf_op_i(rf_op_i), .rf_imm_i(rf_imm_i),
      .rf_qj_i(rf_qj_i), .rf_qk_i(rf_qk_i), .rf_vj_i(rf_vj_i), .rf_vk_i(rf_vk_i),
      .rf_qd_i(rf_qd_i), .rf_pc_i(rf_pc_i),
      .cdb_en_i(cdb_en_i), .cdb_q_i(cdb_q_i), .cdb_v_i(cdb_v_i),
      .ldb_en_i(ldb_en_i), .ldb_q_i(ldb_q_i), .ldb_v_i(ldb_v_i),
      .full_o(full_o), .alu_en_o(alu_en_o), .alu_ic_o(alu_ic_o), .alu_op_o(alu_op_o),
      .alu_vj_o(alu_vj_o), .alu_vk_o(alu_vk_o), .alu_imm_o(alu_imm_o),
      .alu_pc_o(alu_pc_o), .alu_qd_o(alu_qd_o)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic insert(input logic [ROB_BIT-1:0] qj, input logic [ROB_BIT-1:0] qk,
                         input logic [DAT_W-1:0] vj, input logic [DAT_W-1:0] vk,
                         input logic [ROB_BIT-1:0] qd, input logic [DAT_W-1:0] pc);
      rf_en_i = 1'b1;
      rf_op_i = 6'h01;
      rf_ic_i = 1'b0;
      rf_imm_i = 32'h0;
      rf_qj_i = qj;
      rf_qk_i = qk;
      rf_vj_i = vj;
      rf_vk_i = vk;
      rf_qd_i = qd;
      rf_pc_i = pc;
      tick();
      rf_en_i = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL reset_en got=%0h exp=0", alu_en_o); end
      checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full_o); end
      checks++; if (alu_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", alu_pc_o); end
   endtask

   task automatic test_ready_dispatch;
      insert(4'd0, 4'd0, 32'd5, 32'd7, 4'd3, 32'h100);
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t1_no_same_edge got=%0h exp=0", alu_en_o); end
      tick();
      checks++; if (alu_en_o !== 1'b1) begin failures++; $display("FAIL t1_en got=%0h exp=1", alu_en_o); end
      checks++; if (alu_vj_o !== 32'd5 || alu_vk_o !== 32'd7) begin failures++; $display("FAIL t1_vals got=%0h/%0h exp=5/7", alu_vj_o, alu_vk_o); end
      checks++; if (alu_qd_o !== 4'd3 || alu_pc_o !== 32'h100 || alu_op_o !== 6'h01) begin failures++; $display("FAIL t1_tag got=%0h/%0h/%0h exp=3/100/1", alu_qd_o, alu_pc_o, alu_op_o); end
      tick();
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t1_drop got=%0h exp=0", alu_en_o); end
   endtask

   task automatic test_cdb_wakeup;
      insert(4'd4, 4'd0, 32'd0, 32'd9, 4'd5, 32'h104);
      tick();
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t2_wait got=%0h exp=0", alu_en_o); end
      cdb_en_i = 1'b1; cdb_q_i = 4'd4; cdb_v_i = 32'h22;
      tick();
      cdb_en_i = 1'b0;
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t2_no_same_edge got=%0h exp=0", alu_en_o); end
      tick();
      checks++; if (alu_en_o !== 1'b1 || alu_vj_o !== 32'h22 || alu_vk_o !== 32'd9) begin failures++; $display("FAIL t2_wake got=%0h/%0h/%0h exp=1/22/9", alu_en_o, alu_vj_o, alu_vk_o); end
      tick();
   endtask

   task automatic test_ldb_capture;
      ldb_en_i = 1'b1; ldb_q_i = 4'd6; ldb_v_i = 32'hAB;
      insert(4'd6, 4'd0, 32'd0, 32'd1, 4'd7, 32'h108);
      ldb_en_i = 1'b0;
      tick();
      checks++; if (alu_en_o !== 1'b1 || alu_vj_o !== 32'hAB || alu_qd_o !== 4'd7) begin failures++; $display("FAIL t3_capture got=%0h/%0h/%0h exp=1/ab/7", alu_en_o, alu_vj_o, alu_qd_o); end
      tick();
   endtask

   task automatic test_fill_and_drain;
      for (int i = 0; i < 7; i++) begin
         insert(4'd9, 4'd0, 32'd0, 32'd2, 4'(i + 1), 32'h200 + 32'(i));
         if (i == 5) begin
            checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL t4_full6 got=%0h exp=0", full_o); end
         end
      end
      checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL t4_full7 got=%0h exp=1", full_o); end
      cdb_en_i = 1'b1; cdb_q_i = 4'd9; cdb_v_i = 32'h55;
      tick();
      cdb_en_i = 1'b0;
      checks++; if (alu_en_o !== 1'b0 || full_o !== 1'b1) begin failures++; $display("FAIL t4_woken got=%0h/%0h exp=0/1", alu_en_o, full_o); end
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++; if (alu_en_o !== 1'b1 || alu_qd_o !== 4'(i + 1) || alu_vj_o !== 32'h55) begin failures++; $display("FAIL t4_order%0d got=%0h/%0h/%0h exp=1/%0h/55", i, alu_en_o, alu_qd_o, alu_vj_o, i + 1); end
         if (i == 0) begin
            checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL t4_unfull got=%0h exp=0", full_o); end
         end
      end
      tick();
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t4_empty got=%0h exp=0", alu_en_o); end
   endtask

   task automatic test_flush;
      insert(4'd10, 4'd0, 32'd0, 32'd0, 4'd1, 32'h300);
      insert(4'd12, 4'd0, 32'd0, 32'd0, 4'd2, 32'h304);
      insert(4'd11, 4'd0, 32'd0, 32'd0, 4'd3, 32'h308);
      cdb_en_i = 1'b1; cdb_q_i = 4'd10; cdb_v_i = 32'h1;
      ldb_en_i = 1'b1; ldb_q_i = 4'd11; ldb_v_i = 32'h3;
      tick();
      cdb_en_i = 1'b0; ldb_en_i = 1'b0;
      tick();
      checks++; if (alu_en_o !== 1'b1 || alu_pc_o !== 32'h300) begin failures++; $display("FAIL t5_first got=%0h/%0h exp=1/300", alu_en_o, alu_pc_o); end
      tick();
      checks++; if (alu_en_o !== 1'b1 || alu_pc_o !== 32'h308 || alu_vj_o !== 32'h3) begin failures++; $display("FAIL t5_second got=%0h/%0h/%0h exp=1/308/3", alu_en_o, alu_pc_o, alu_vj_o); end
      tick();
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t5_hold got=%0h exp=0", alu_en_o); end
      br_flag = 1'b1;
      tick();
      br_flag = 1'b0;
      checks++; if (alu_en_o !== 1'b0 || full_o !== 1'b0 || alu_qd_o !== 4'd0) begin failures++; $display("FAIL t5_flush got=%0h/%0h/%0h exp=0/0/0", alu_en_o, full_o, alu_qd_o); end
      cdb_en_i = 1'b1; cdb_q_i = 4'd12; cdb_v_i = 32'h7;
      tick();
      cdb_en_i = 1'b0;
      tick();
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t5_gone got=%0h exp=0", alu_en_o); end
   endtask

   task automatic test_enable_freeze;
      insert(4'd13, 4'd0, 32'd0, 32'd0, 4'd4, 32'h400);
      insert(4'd0, 4'd0, 32'd8, 32'd8, 4'd5, 32'h404);
      en = 1'b0;
      cdb_en_i = 1'b1; cdb_q_i = 4'd13; cdb_v_i = 32'h77;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t6_frozen%0d got=%0h exp=0", i, alu_en_o); end
      end
      cdb_en_i = 1'b0;
      en = 1'b1;
      tick();
      checks++; if (alu_en_o !== 1'b1 || alu_qd_o !== 4'd5) begin failures++; $display("FAIL t6_resume got=%0h/%0h exp=1/5", alu_en_o, alu_qd_o); end
      tick();
      checks++; if (alu_en_o !== 1'b0) begin failures++; $display("FAIL t6_missed got=%0h exp=0", alu_en_o); end
      cdb_en_i = 1'b1; cdb_q_i = 4'd13; cdb_v_i = 32'h99;
      tick();
      cdb_en_i = 1'b0;
      tick();
      checks++; if (alu_en_o !== 1'b1 || alu_vj_o !== 32'h99 || alu_qd_o !== 4'd4) begin failures++; $display("FAIL t6_late got=%0h/%0h/%0h exp=1/99/4", alu_en_o, alu_vj_o, alu_qd_o); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; br_flag = 1'b0;
      rf_en_i = 1'b0; rf_ic_i = 1'b0; rf_op_i = '0; rf_imm_i = '0;
      rf_qj_i = '0; rf_qk_i = '0; rf_vj_i = '0; rf_vk_i = '0; rf_qd_i = '0; rf_pc_i = '0;
      cdb_en_i = 1'b0; cdb_q_i = '0; cdb_v_i = '0;
      ldb_en_i = 1'b0; ldb_q_i = '0; ldb_v_i = '0;
      test_reset();
      test_ready_dispatch();
      test_cdb_wakeup();
      test_ldb_capture();
      test_fill_and_drain();
      test_flush();
      test_enable_freeze();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
